// File: rtl/instr_fetch.sv
// instr_fetch: MIPS instruction-fetch stage, owns the fetch PC and feeds decode.
// Latency: one edge from IMem ack to Instr1/Instr_PC outputs when not frozen.
// Backpressure: freeze (WANT_FREEZE | STALL) holds outputs; one acked word is buffered in HOLD.
//
// Ports:
//   CLK, RESET (async, active-low)
//   Alt_PC_IN / Request_Alt_PC_IN   : registered redirect from decode
//   WANT_FREEZE_IN, STALL_IN        : freeze sources
//   IMem_Addr_OUT / IMem_Req_OUT    : fetch request (address = PC)
//   IMem_Ack_IN / IMem_Data_IN      : instruction word for this cycle's address
//   Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT : delivery to decode (bubble = word 0)
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Alt_PC_IN,
  input  logic        Request_Alt_PC_IN,
  input  logic        WANT_FREEZE_IN,
  input  logic        STALL_IN,
  output logic [31:0] IMem_Addr_OUT,
  output logic        IMem_Req_OUT,
  input  logic        IMem_Ack_IN,
  input  logic [31:0] IMem_Data_IN,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4_OUT
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        adv_q, adv_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;

  logic        freeze;
  logic        valid_redir;
  logic        eff_redir;
  logic [31:0] redir_tgt;
  logic [31:0] pc_plus4;

  assign freeze      = WANT_FREEZE_IN | STALL_IN;
  // Decode re-registers its redirect every cycle from a held instruction, so
  // only the first cycle after an unfrozen one carries a genuine request.
  assign valid_redir = Request_Alt_PC_IN & adv_q;
  assign eff_redir   = valid_redir | pend_v_q;
  // A fresh redirect is newer than anything recorded while frozen.
  assign redir_tgt   = valid_redir ? Alt_PC_IN : pend_tgt_q;
  assign pc_plus4    = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    adv_d       = ~freeze;
    pend_v_d    = pend_v_q;
    pend_tgt_d  = pend_tgt_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    instr_d     = instr_q;
    ipc_d       = ipc_q;
    ipc4_d      = ipc4_q;

    // A redirect seen while frozen is remembered until the first unfrozen cycle.
    if (freeze && valid_redir) begin
      pend_v_d   = 1'b1;
      pend_tgt_d = Alt_PC_IN;
    end

    case (state_q)
      S_INIT: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (freeze) begin
          if (IMem_Ack_IN) begin
            buf_instr_d = IMem_Data_IN;
            buf_pc_d    = pc_q;
            pc_d        = pc_plus4;
            state_d     = S_HOLD;
          end
        end else if (eff_redir) begin
          // Word fetched this cycle is wrong-path; drop it.
          instr_d  = 32'd0;
          pc_d     = redir_tgt;
          pend_v_d = 1'b0;
        end else if (IMem_Ack_IN) begin
          instr_d = IMem_Data_IN;
          ipc_d   = pc_q;
          ipc4_d  = pc_plus4;
          pc_d    = pc_plus4;
        end else begin
          instr_d = 32'd0;
        end
      end

      S_HOLD: begin
        if (!freeze) begin
          state_d = S_FETCH;
          if (eff_redir) begin
            instr_d  = 32'd0;
            pc_d     = redir_tgt;
            pend_v_d = 1'b0;
          end else begin
            instr_d = buf_instr_q;
            ipc_d   = buf_pc_q;
            ipc4_d  = buf_pc_q + 32'd4;
          end
        end
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_INIT;
      pc_q        <= RESET_PC;
      adv_q       <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_tgt_q  <= 32'd0;
      buf_instr_q <= 32'd0;
      buf_pc_q    <= 32'd0;
      instr_q     <= 32'd0;
      ipc_q       <= 32'd0;
      ipc4_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      adv_q       <= adv_d;
      pend_v_q    <= pend_v_d;
      pend_tgt_q  <= pend_tgt_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      instr_q     <= instr_d;
      ipc_q       <= ipc_d;
      ipc4_q      <= ipc4_d;
    end
  end

  assign IMem_Addr_OUT      = pc_q;
  assign IMem_Req_OUT       = (state_q == S_FETCH);
  assign Instr1_OUT         = instr_q;
  assign Instr_PC_OUT       = ipc_q;
  assign Instr_PC_Plus4_OUT = ipc4_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed + random stimulus against a queue-based fetch model.
// Latency: model outputs compared each negedge, one edge after the inputs that produced them.
// Backpressure: freeze, stall and redirect are driven directly; memory ack is random.
module tb_instr_fetch;

  localparam logic [31:0] RPC = 32'h00400000;

  logic        CLK;
  logic        RESET;
  logic [31:0] Alt_PC_IN;
  logic        Request_Alt_PC_IN;
  logic        WANT_FREEZE_IN;
  logic        STALL_IN;
  logic [31:0] IMem_Addr_OUT;
  logic        IMem_Req_OUT;
  logic        IMem_Ack_IN;
  logic [31:0] IMem_Data_IN;
  logic [31:0] Instr1_OUT;
  logic [31:0] Instr_PC_OUT;
  logic [31:0] Instr_PC_Plus4_OUT;

  instr_fetch #(.RESET_PC(RPC)) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .Alt_PC_IN          (Alt_PC_IN),
    .Request_Alt_PC_IN  (Request_Alt_PC_IN),
    .WANT_FREEZE_IN     (WANT_FREEZE_IN),
    .STALL_IN           (STALL_IN),
    .IMem_Addr_OUT      (IMem_Addr_OUT),
    .IMem_Req_OUT       (IMem_Req_OUT),
    .IMem_Ack_IN        (IMem_Ack_IN),
    .IMem_Data_IN       (IMem_Data_IN),
    .Instr1_OUT         (Instr1_OUT),
    .Instr_PC_OUT       (Instr_PC_OUT),
    .Instr_PC_Plus4_OUT (Instr_PC_Plus4_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the fetch stage as "a PC, at most one parked word, at most
  // one remembered redirect target, and the last thing handed to decode".
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic [31:0] m_pc;
  bit          m_started;
  bit          m_adv;
  ent_t        m_buf[$];
  logic [31:0] m_pend[$];
  logic [31:0] m_instr, m_ipc, m_ipc4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_5A5A;
  endfunction

  task automatic model_reset();
    m_pc      = RPC;
    m_started = 1'b0;
    m_adv     = 1'b0;
    m_buf.delete();
    m_pend.delete();
    m_instr   = 32'd0;
    m_ipc     = 32'd0;
    m_ipc4    = 32'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic req_exp;
    req_exp = m_started && (m_buf.size() == 0);
    check({tag, ".instr"}, Instr1_OUT, m_instr);
    check({tag, ".pc"},    Instr_PC_OUT, m_ipc);
    check({tag, ".pc4"},   Instr_PC_Plus4_OUT, m_ipc4);
    check({tag, ".addr"},  IMem_Addr_OUT, m_pc);
    check({tag, ".req"},   {31'd0, IMem_Req_OUT}, {31'd0, req_exp});
  endtask

  // One cycle: check current outputs, drive inputs, advance model at the edge.
  task automatic step(input string tag, input bit ack, input bit wf, input bit st,
                      input bit rq, input logic [31:0] alt);
    bit          frozen, redir_now, fetching;
    logic [31:0] data, tgt;
    ent_t        e;
    check_all(tag);
    data              = mem_word(m_pc);
    IMem_Ack_IN       = ack;
    IMem_Data_IN      = data;
    WANT_FREEZE_IN    = wf;
    STALL_IN          = st;
    Request_Alt_PC_IN = rq;
    Alt_PC_IN         = alt;
    @(posedge CLK);
    frozen    = wf || st;
    redir_now = rq && m_adv;
    fetching  = m_started && (m_buf.size() == 0);
    if (frozen && redir_now) begin
      m_pend.delete();
      m_pend.push_back(alt);
    end
    if (!m_started) begin
      m_started = 1'b1;
    end else if (frozen) begin
      if (fetching && ack) begin
        m_buf.push_back({data, m_pc});
        m_pc = m_pc + 32'd4;
      end
    end else if (redir_now || m_pend.size() > 0) begin
      tgt = redir_now ? alt : m_pend[0];
      m_pend.delete();
      m_buf.delete();
      m_instr = 32'd0;
      m_pc    = tgt;
    end else if (m_buf.size() > 0) begin
      e       = m_buf.pop_front();
      m_instr = e.instr;
      m_ipc   = e.pc;
      m_ipc4  = e.pc + 32'd4;
    end else if (ack) begin
      m_instr = data;
      m_ipc   = m_pc;
      m_ipc4  = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
    end else begin
      m_instr = 32'd0;
    end
    m_adv = !frozen;
    @(negedge CLK);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without an edge.
  task automatic do_reset(input string tag);
    RESET             = 1'b0;
    IMem_Ack_IN       = 1'b0;
    IMem_Data_IN      = 32'd0;
    WANT_FREEZE_IN    = 1'b0;
    STALL_IN          = 1'b0;
    Request_Alt_PC_IN = 1'b0;
    Alt_PC_IN         = 32'd0;
    #1;
    check({tag, ".rst_instr"}, Instr1_OUT, 32'd0);
    check({tag, ".rst_pc"},    Instr_PC_OUT, 32'd0);
    check({tag, ".rst_pc4"},   Instr_PC_Plus4_OUT, 32'd0);
    check({tag, ".rst_addr"},  IMem_Addr_OUT, RPC);
    check({tag, ".rst_req"},   {31'd0, IMem_Req_OUT}, 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    check({tag, ".rst_hold_req"}, {31'd0, IMem_Req_OUT}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    RESET             = 1'b0;
    IMem_Ack_IN       = 1'b0;
    IMem_Data_IN      = 32'd0;
    WANT_FREEZE_IN    = 1'b0;
    STALL_IN          = 1'b0;
    Request_Alt_PC_IN = 1'b0;
    Alt_PC_IN         = 32'd0;
    model_reset();
    @(negedge CLK);
    do_reset("por");

    // Streaming with ack every cycle; first cycle after release has Req=0.
    for (int i = 0; i < 6; i++) step("stream", 1, 0, 0, 0, 32'd0);

    // Ack withheld for three cycles, then resumes.
    for (int i = 0; i < 3; i++) step("noack", 0, 0, 0, 0, 32'd0);
    for (int i = 0; i < 3; i++) step("resume", 1, 0, 0, 0, 32'd0);

    // Branch at 0x100, delay slot 0x104, redirect to 0x200 while 0x108 is fetched.
    step("to100", 1, 0, 0, 1, 32'h00000100);
    step("br",    1, 0, 0, 0, 32'd0);
    step("dslot", 1, 0, 0, 0, 32'd0);
    step("redir", 1, 0, 0, 1, 32'h00000200);
    for (int i = 0; i < 3; i++) step("tgt", 1, 0, 0, 0, 32'd0);

    // Freeze for four cycles with an ack in the first one.
    step("frz0", 1, 1, 0, 0, 32'd0);
    for (int i = 0; i < 3; i++) step("frz", 1, 1, 0, 0, 32'd0);
    for (int i = 0; i < 3; i++) step("unfrz", 1, 0, 0, 0, 32'd0);

    // Valid redirect with stall, repeated request while adv_q=0 ignored.
    step("stl0", 1, 0, 1, 1, 32'h00000300);
    step("stl1", 1, 0, 1, 1, 32'h00000990);
    for (int i = 0; i < 3; i++) step("stlrel", 1, 0, 0, 0, 32'd0);

    // Wrap of +4 at the top of the address space.
    step("wrap0", 1, 0, 0, 1, 32'hFFFFFFFC);
    for (int i = 0; i < 3; i++) step("wrap", 1, 0, 0, 0, 32'd0);

    // Reset in HOLD with a redirect pending.
    step("hold0", 1, 1, 0, 1, 32'h00000500);
    step("hold1", 1, 1, 0, 0, 32'd0);
    do_reset("midhold");
    for (int i = 0; i < 4; i++) step("restart", 1, 0, 0, 0, 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit ack, wf, st, rq;
      logic [31:0] alt;
      ack = ($urandom_range(99) < 70);
      wf  = ($urandom_range(99) < 10);
      st  = ($urandom_range(99) < 15);
      rq  = ($urandom_range(99) < 12);
      alt = ($urandom_range(9) == 0) ? 32'hFFFFFFF8 : $urandom;
      step("rand", ack, wf, st, rq, alt);
    end
    step("final", 0, 0, 0, 0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage for the MIPS pipeline, and the producer side of the fetch→decode interface. It owns the architectural fetch PC and issues requests to instruction memory. It delivers instruction, PC and PC+4 to decode, and consumes decode's registered branch/jump redirect (`Alt_PC`/`Request_Alt_PC`) and freeze request (`WANT_FREEZE`). Bubbles are delivered as instruction word 0 (`sll $0,$0,0`), which decode treats as a NOP.

## Interface
- `RESET_PC`, 32'h00400000, PC loaded on reset.
- `CLK` input 1: single clock, rising edge.
- `RESET` input 1: asynchronous, active-low reset.
- `Alt_PC_IN` input 32: branch/jump target from decode (registered there).
- `Request_Alt_PC_IN` input 1: decode requests a redirect (registered there).
- `WANT_FREEZE_IN` input 1: decode freeze request (syscall / LL/SC flush).
- `STALL_IN` input 1: hazard stall from forwarding/hazard logic.
- `IMem_Addr_OUT` output 32: fetch address (equals PC).
- `IMem_Req_OUT` output 1: fetch request.
- `IMem_Ack_IN` input 1: `IMem_Data_IN` is valid for the address presented this cycle.
- `IMem_Data_IN` input 32: instruction word.
- `Instr1_OUT` output 32: instruction to decode.
- `Instr_PC_OUT` output 32: PC of `Instr1_OUT`.
- `Instr_PC_Plus4_OUT` output 32: `Instr_PC_OUT`+4.

## Operation
- Definitions:
  - freeze = `WANT_FREEZE_IN` | `STALL_IN`.
  - `adv_q` register = !freeze of the previous cycle.
  - valid redirect = `Request_Alt_PC_IN` & `adv_q`. `Request_Alt_PC_IN` is ignored when `adv_q`=0, because decode re-registers it every cycle from a held instruction.
- States:
  - INIT (after reset): Req=0; next state FETCH.
  - FETCH: Req=1, Addr=PC.
  - HOLD: Req=0; one fetched instruction is buffered (`buf_instr`, `buf_pc`).
- Pending-redirect register (`pend_v`, `pend_tgt`):
  - Set when a valid redirect is seen during a frozen cycle.
  - Cleared when applied.
  - The effective redirect in an unfrozen cycle is the valid redirect if present, otherwise `pend_v`. `Alt_PC_IN` takes priority over `pend_tgt`.
- FETCH, unfrozen, in priority order:
  1. Redirect: discard any Ack data; deliver a bubble; PC ← target; clear `pend_v`.
  2. Ack: deliver {`IMem_Data_IN`, PC, PC+4}; PC ← PC+4.
  3. No Ack: deliver a bubble; PC unchanged.
- FETCH, frozen:
  - Outputs hold.
  - Ack → buffer {data, PC}; PC ← PC+4; go to HOLD.
  - No Ack → no change.
- HOLD, frozen: everything holds; a valid redirect only sets pending.
- HOLD, unfrozen:
  - With redirect: discard the buffer, deliver a bubble, PC ← target, go to FETCH.
  - Without redirect: deliver {`buf_instr`, `buf_pc`, `buf_pc`+4}; go to FETCH.
- "Deliver a bubble": `Instr1_OUT` ← 0; `Instr_PC_OUT` and `Instr_PC_Plus4_OUT` hold their values.
- Arithmetic: all +4 operations are 32-bit and wrap modulo 2^32 (0xFFFFFFFC+4 = 0). PC bits [1:0] are taken as given from `Alt_PC_IN`; no alignment check.
- Memory contract: Addr may change while Req=1; an Ack applies only to that cycle's address. No outstanding request survives a redirect.
- Branch delay slot: decode raises the redirect in the cycle after the branch leaves decode, so the delay slot has already been delivered. The instruction fetched in the redirect cycle is wrong-path and is dropped (one-cycle penalty beyond the delay slot).

## Timing
- Reset (asynchronous, all registers):
  - Registers: PC=`RESET_PC`, state=INIT, `adv_q`=0, `pend_v`=0, `pend_tgt`=0, `buf_instr`=0, `buf_pc`=0.
  - Outputs: `Instr1_OUT`=0, `Instr_PC_OUT`=0, `Instr_PC_Plus4_OUT`=0, `IMem_Req_OUT`=0. `IMem_Addr_OUT`=`RESET_PC`.
- First request: the cycle after reset release. With Ack in that cycle, the instruction appears on the outputs one edge later.
- Request-to-output latency: 1 edge after Ack, when not frozen.
- Reset asserted mid-HOLD or with a redirect pending: both are discarded and the reset values apply immediately.
- Freeze and redirect in the same cycle: the redirect is recorded as pending and applied in the first unfrozen cycle.
- Ack and redirect in the same cycle: the redirect wins and the data is dropped.

## Test plan
- Reset release with `RESET_PC`=0x00400000 and Ack every cycle → the outputs show PC 0x00400000, 0x00400004, 0x00400008 on consecutive cycles with matching `IMem_Data_IN`; `IMem_Req_OUT`=0 in the first cycle.
- Ack withheld for 3 cycles → three bubbles (`Instr1_OUT`=0, PC outputs held); `IMem_Addr_OUT` stays constant; delivery resumes in order.
- Branch at 0x100 and delay slot at 0x104 delivered, then `Request_Alt_PC_IN`=1 with `Alt_PC_IN`=0x200 → the fetch of 0x108 is dropped, one bubble is delivered, and the next delivered PC is 0x200.
- `WANT_FREEZE_IN` held 4 cycles with an Ack during the freeze → the outputs hold, state goes to HOLD, Req=0; on release the buffered instruction is delivered with the correct PC and fetch resumes at that PC+4.
- Valid redirect (`adv_q`=1) arriving together with `STALL_IN`=1 for 2 cycles → pending is set; in the first unfrozen cycle a bubble is delivered and the PC jumps to the target. `Request_Alt_PC_IN` high during the remaining frozen cycles (`adv_q`=0) has no effect.
- Reset asserted while in HOLD with a redirect pending → immediately all outputs are 0 and PC=`RESET_PC`; after release, fetch starts cleanly at `RESET_PC`.
